// File: rtl/i8088_bus_pkg.sv
// Shared definitions for the AXI-Lite to 8088 bus bridge.
//   bus_state_t : bus-cycle sequencer states (IDLE, T1..T4, TW, RESP)
//   IO_SEL_BIT  : AXI address bit that selects an IO cycle instead of memory
//   RESP_*      : AXI response codes
//   lane_byte() : selects byte lane L of a 32-bit word
package i8088_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_TW,
    ST_T4,
    ST_RESP
  } bus_state_t;

  localparam int unsigned IO_SEL_BIT = 21;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] l);
    return w[{l, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/axi_i8088_bus_master_tstate_timer.sv
// T-state timer: counts AXI_CLK cycles within one 8088 T-state.
//   AXI_CLK  : clock
//   RESET    : async active-high reset
//   restart  : zero the count on the next edge (asserted when a state is entered)
//   t_end    : high on the last cycle of the current T-state
module i8088_tstate_timer #(
  parameter int unsigned CYCLES_PER_T = 4
) (
  input  logic AXI_CLK,
  input  logic RESET,
  input  logic restart,
  output logic t_end
);

  localparam logic [7:0] LAST = 8'(CYCLES_PER_T - 1);

  logic [7:0] cnt;

  assign t_end = (cnt == LAST);

  always_ff @(posedge AXI_CLK or posedge RESET) begin
    if (RESET) begin
      cnt <= '0;
    end else if (restart || t_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/axi_i8088_bus_master.sv
// AXI-Lite slave that turns each single-beat access into one 8088 bus cycle.
//   AXI_CLK, RESET          : clock, async active-high reset
//   AXI_aw*/w*/b*           : AXI-Lite write channel (one byte lane used per access)
//   AXI_ar*/r*              : AXI-Lite read channel (byte replicated in all lanes)
//   A_bus, IO_nM_bus        : 20-bit address and IO/memory select, held T1..T4
//   ALE_bus, nRD_bus, nWR_bus : bus strobes
//   AD8_out_bus/enout/in    : multiplexed data path
//   READY_bus               : wait-state request, sampled at the end of T3/TW
module axi_i8088_bus_master
  import i8088_bus_pkg::*;
#(
  parameter int unsigned CYCLES_PER_T = 4,
  parameter int unsigned TIMEOUT_TW   = 64
) (
  input  logic        AXI_CLK,
  input  logic        RESET,
  input  logic [31:0] AXI_awaddr,
  input  logic        AXI_awvalid,
  output logic        AXI_awready,
  input  logic [31:0] AXI_wdata,
  input  logic [3:0]  AXI_wstrb,
  input  logic        AXI_wvalid,
  output logic        AXI_wready,
  output logic [1:0]  AXI_bresp,
  output logic        AXI_bvalid,
  input  logic        AXI_bready,
  input  logic [31:0] AXI_araddr,
  input  logic        AXI_arvalid,
  output logic        AXI_arready,
  output logic [31:0] AXI_rdata,
  output logic [1:0]  AXI_rresp,
  output logic        AXI_rvalid,
  input  logic        AXI_rready,
  output logic [19:0] A_bus,
  output logic [7:0]  AD8_out_bus,
  output logic        AD8_enout_bus,
  input  logic [7:0]  AD8_in_bus,
  output logic        ALE_bus,
  output logic        nRD_bus,
  output logic        nWR_bus,
  output logic        IO_nM_bus,
  input  logic        READY_bus
);

  localparam logic [9:0] TW_LIMIT = 10'(TIMEOUT_TW);

  bus_state_t  state;
  logic        run_en;     // low in reset and for one cycle after, keeps readies at 0
  logic        is_wr;
  logic [7:0]  wbyte;
  logic [1:0]  resp;
  logic [31:0] rd_data;
  logic [9:0]  tw_cnt;
  logic        t_end;
  logic        accept_wr;
  logic        accept_rd;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{AXI_awaddr[31:22], AXI_awaddr[20], AXI_araddr[31:22], AXI_araddr[20]};

  assign accept_wr   = run_en && (state == ST_IDLE) && AXI_awvalid && AXI_wvalid;
  assign accept_rd   = run_en && (state == ST_IDLE) && AXI_arvalid && !(AXI_awvalid && AXI_wvalid);
  assign AXI_awready = accept_wr;
  assign AXI_wready  = accept_wr;
  assign AXI_arready = accept_rd;

  // Held in restart while idle so T1 starts with a fresh count; every
  // t_end thereafter coincides with a state entry.
  i8088_tstate_timer #(
    .CYCLES_PER_T(CYCLES_PER_T)
  ) u_timer (
    .AXI_CLK(AXI_CLK),
    .RESET  (RESET),
    .restart(state == ST_IDLE),
    .t_end  (t_end)
  );

  always_ff @(posedge AXI_CLK or posedge RESET) begin
    if (RESET) begin
      state         <= ST_IDLE;
      run_en        <= 1'b0;
      is_wr         <= 1'b0;
      wbyte         <= '0;
      resp          <= RESP_OKAY;
      rd_data       <= '0;
      tw_cnt        <= '0;
      A_bus         <= '0;
      IO_nM_bus     <= 1'b0;
      ALE_bus       <= 1'b0;
      nRD_bus       <= 1'b1;
      nWR_bus       <= 1'b1;
      AD8_out_bus   <= '0;
      AD8_enout_bus <= 1'b0;
      AXI_bvalid    <= 1'b0;
      AXI_bresp     <= '0;
      AXI_rvalid    <= 1'b0;
      AXI_rresp     <= '0;
      AXI_rdata     <= '0;
    end else begin
      run_en <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (accept_wr) begin
            is_wr <= 1'b1;
            wbyte <= lane_byte(AXI_wdata, AXI_awaddr[1:0]);
            if (AXI_wstrb[AXI_awaddr[1:0]]) begin
              state     <= ST_T1;
              ALE_bus   <= 1'b1;
              A_bus     <= AXI_awaddr[19:0];
              IO_nM_bus <= AXI_awaddr[IO_SEL_BIT];
            end else begin
              // Addressed byte not enabled: no bus cycle, error straight away.
              state      <= ST_RESP;
              AXI_bvalid <= 1'b1;
              AXI_bresp  <= RESP_SLVERR;
            end
          end else if (accept_rd) begin
            is_wr     <= 1'b0;
            state     <= ST_T1;
            ALE_bus   <= 1'b1;
            A_bus     <= AXI_araddr[19:0];
            IO_nM_bus <= AXI_araddr[IO_SEL_BIT];
          end
        end
        ST_T1: begin
          if (t_end) begin
            state         <= ST_T2;
            ALE_bus       <= 1'b0;
            nRD_bus       <= is_wr;
            nWR_bus       <= !is_wr;
            AD8_enout_bus <= is_wr;
            AD8_out_bus   <= is_wr ? wbyte : '0;
          end
        end
        ST_T2: begin
          if (t_end) begin
            state <= ST_T3;
          end
        end
        ST_T3, ST_TW: begin
          if (t_end) begin
            if (READY_bus) begin
              state   <= ST_T4;
              nRD_bus <= 1'b1;
              nWR_bus <= 1'b1;
              resp    <= RESP_OKAY;
              rd_data <= {4{AD8_in_bus}};
            end else if ((state == ST_TW) && (tw_cnt == TW_LIMIT)) begin
              state   <= ST_T4;
              nRD_bus <= 1'b1;
              nWR_bus <= 1'b1;
              resp    <= RESP_SLVERR;
              rd_data <= '1;
            end else begin
              state  <= ST_TW;
              tw_cnt <= (state == ST_T3) ? 10'd1 : tw_cnt + 10'd1;
            end
          end
        end
        ST_T4: begin
          if (t_end) begin
            state         <= ST_RESP;
            AD8_enout_bus <= 1'b0;
            AD8_out_bus   <= '0;
            if (is_wr) begin
              AXI_bvalid <= 1'b1;
              AXI_bresp  <= resp;
            end else begin
              AXI_rvalid <= 1'b1;
              AXI_rresp  <= resp;
              AXI_rdata  <= rd_data;
            end
          end
        end
        ST_RESP: begin
          if ((AXI_bvalid && AXI_bready) || (AXI_rvalid && AXI_rready)) begin
            state      <= ST_IDLE;
            AXI_bvalid <= 1'b0;
            AXI_rvalid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_i8088_bus_master.sv
module tb_axi_i8088_bus_master;

  logic        AXI_CLK;
  logic        RESET;
  logic [31:0] AXI_awaddr;
  logic        AXI_awvalid;
  logic        AXI_awready;
  logic [31:0] AXI_wdata;
  logic [3:0]  AXI_wstrb;
  logic        AXI_wvalid;
  logic        AXI_wready;
  logic [1:0]  AXI_bresp;
  logic        AXI_bvalid;
  logic        AXI_bready;
  logic [31:0] AXI_araddr;
  logic        AXI_arvalid;
  logic        AXI_arready;
  logic [31:0] AXI_rdata;
  logic [1:0]  AXI_rresp;
  logic        AXI_rvalid;
  logic        AXI_rready;
  logic [19:0] A_bus;
  logic [7:0]  AD8_out_bus;
  logic        AD8_enout_bus;
  logic [7:0]  AD8_in_bus;
  logic        ALE_bus;
  logic        nRD_bus;
  logic        nWR_bus;
  logic        IO_nM_bus;
  logic        READY_bus;

  axi_i8088_bus_master #(
    .CYCLES_PER_T(4),
    .TIMEOUT_TW  (64)
  ) dut (
    .AXI_CLK      (AXI_CLK),
    .RESET        (RESET),
    .AXI_awaddr   (AXI_awaddr),
    .AXI_awvalid  (AXI_awvalid),
    .AXI_awready  (AXI_awready),
    .AXI_wdata    (AXI_wdata),
    .AXI_wstrb    (AXI_wstrb),
    .AXI_wvalid   (AXI_wvalid),
    .AXI_wready   (AXI_wready),
    .AXI_bresp    (AXI_bresp),
    .AXI_bvalid   (AXI_bvalid),
    .AXI_bready   (AXI_bready),
    .AXI_araddr   (AXI_araddr),
    .AXI_arvalid  (AXI_arvalid),
    .AXI_arready  (AXI_arready),
    .AXI_rdata    (AXI_rdata),
    .AXI_rresp    (AXI_rresp),
    .AXI_rvalid   (AXI_rvalid),
    .AXI_rready   (AXI_rready),
    .A_bus        (A_bus),
    .AD8_out_bus  (AD8_out_bus),
    .AD8_enout_bus(AD8_enout_bus),
    .AD8_in_bus   (AD8_in_bus),
    .ALE_bus      (ALE_bus),
    .nRD_bus      (nRD_bus),
    .nWR_bus      (nWR_bus),
    .IO_nM_bus    (IO_nM_bus),
    .READY_bus    (READY_bus)
  );

  initial AXI_CLK = 1'b0;
  always #5 AXI_CLK = ~AXI_CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Per-transaction observations gathered by run_to_resp.
  int          r_lat, r_ale, r_nrd, r_nwr, r_en, r_ar_seen, r_unstable;
  logic [19:0] r_a;
  logic        r_io;
  logic [7:0]  r_ad;
  logic [31:0] r_data;
  logic [1:0]  r_resp;

  task automatic issue_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input string tag);
    @(posedge AXI_CLK); #1;
    AXI_awaddr = addr; AXI_wdata = data; AXI_wstrb = strb;
    AXI_awvalid = 1'b1; AXI_wvalid = 1'b1;
    @(negedge AXI_CLK);
    check({tag, "_awready"}, 32'(AXI_awready), 32'd1);
  endtask

  task automatic issue_rd(input logic [31:0] addr, input string tag);
    @(posedge AXI_CLK); #1;
    AXI_araddr = addr; AXI_arvalid = 1'b1;
    @(negedge AXI_CLK);
    check({tag, "_arready"}, 32'(AXI_arready), 32'd1);
  endtask

  // Cycle k=1 is the first cycle after the accept cycle; stops at the first
  // cycle showing bvalid/rvalid (r_lat = k) or gives up with r_lat = -1.
  task automatic run_to_resp(input bit clr_wr, input bit clr_rd, input int ready_from,
                             input logic [7:0] din_early, input logic [7:0] din_at);
    r_lat = -1; r_ale = 0; r_nrd = 0; r_nwr = 0; r_en = 0; r_ar_seen = 0; r_unstable = 0;
    r_ad = '0; r_data = '0; r_resp = '0; r_a = '0; r_io = 1'b0;
    for (int k = 1; k <= 2000; k++) begin
      @(posedge AXI_CLK); #1;
      if (k == 1) begin
        if (clr_wr) begin AXI_awvalid = 1'b0; AXI_wvalid = 1'b0; end
        if (clr_rd) AXI_arvalid = 1'b0;
      end
      READY_bus  = (k >= ready_from);
      AD8_in_bus = (k == ready_from) ? din_at : din_early;
      @(negedge AXI_CLK);
      if (ALE_bus) r_ale++;
      if (!nRD_bus) r_nrd++;
      if (!nWR_bus) r_nwr++;
      if (AXI_arready) r_ar_seen++;
      if (AD8_enout_bus) begin r_en++; r_ad = AD8_out_bus; end
      if (k == 1) begin
        r_a = A_bus; r_io = IO_nM_bus;
      end else if (!AXI_bvalid && !AXI_rvalid && (A_bus !== r_a || IO_nM_bus !== r_io)) begin
        r_unstable = 1;
      end
      if (AXI_bvalid || AXI_rvalid) begin
        r_lat  = k;
        r_data = AXI_rdata;
        r_resp = AXI_bvalid ? AXI_bresp : AXI_rresp;
        break;
      end
    end
  endtask

  int bad;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1;
    AXI_awaddr = '0; AXI_awvalid = 1'b0; AXI_wdata = '0; AXI_wstrb = '0; AXI_wvalid = 1'b0;
    AXI_araddr = '0; AXI_arvalid = 1'b0; AXI_bready = 1'b1; AXI_rready = 1'b1;
    AD8_in_bus = '0; READY_bus = 1'b1;

    // Reset values, with a complete write request pending that must not be taken.
    repeat (2) @(negedge AXI_CLK);
    AXI_awvalid = 1'b1; AXI_wvalid = 1'b1; AXI_arvalid = 1'b1;
    @(negedge AXI_CLK);
    check("rst_awready", 32'(AXI_awready), 32'd0);
    check("rst_arready", 32'(AXI_arready), 32'd0);
    check("rst_strobes", {28'd0, ALE_bus, nRD_bus, nWR_bus, IO_nM_bus}, 32'h6);
    check("rst_A_bus", 32'(A_bus), 32'd0);
    check("rst_data_out", {23'd0, AD8_enout_bus, AD8_out_bus}, 32'd0);
    check("rst_valids", {30'd0, AXI_bvalid, AXI_rvalid}, 32'd0);
    check("rst_resps", {28'd0, AXI_bresp, AXI_rresp}, 32'd0);
    check("rst_rdata", AXI_rdata, 32'd0);
    AXI_awvalid = 1'b0; AXI_wvalid = 1'b0; AXI_arvalid = 1'b0;
    @(posedge AXI_CLK); #1;
    RESET = 1'b0;
    repeat (2) @(posedge AXI_CLK);

    // A lone awvalid or a lone wvalid is never accepted.
    #1;
    AXI_awaddr = 32'h0000_0100; AXI_awvalid = 1'b1; AXI_wstrb = 4'hF;
    repeat (3) @(negedge AXI_CLK);
    check("lone_aw_ready", {30'd0, AXI_awready, AXI_wready}, 32'd0);
    check("lone_aw_ale", 32'(ALE_bus), 32'd0);
    AXI_awvalid = 1'b0; AXI_wvalid = 1'b1;
    repeat (3) @(negedge AXI_CLK);
    check("lone_w_ready", {30'd0, AXI_awready, AXI_wready}, 32'd0);
    check("lone_w_ale", 32'(ALE_bus), 32'd0);
    AXI_wvalid = 1'b0;

    // Memory write, lane 3.
    issue_wr(32'h0001_2343, 32'hAB00_0000, 4'b1000, "mw");
    run_to_resp(1'b1, 1'b1, 0, 8'h00, 8'h00);
    check("mw_latency", 32'(r_lat), 32'd17);
    check("mw_A_bus", 32'(r_a), 32'h12343);
    check("mw_io", 32'(r_io), 32'd0);
    check("mw_ad8", 32'(r_ad), 32'hAB);
    check("mw_nwr_low", 32'(r_nwr), 32'd8);
    check("mw_nrd_low", 32'(r_nrd), 32'd0);
    check("mw_ale_cycles", 32'(r_ale), 32'd4);
    check("mw_enout_cycles", 32'(r_en), 32'd12);
    check("mw_addr_stable", 32'(r_unstable), 32'd0);
    check("mw_bresp", 32'(r_resp), 32'd0);

    // IO read.
    issue_rd(32'h0020_0060, "ior");
    run_to_resp(1'b1, 1'b1, 0, 8'h5A, 8'h5A);
    check("ior_latency", 32'(r_lat), 32'd17);
    check("ior_A_bus", 32'(r_a), 32'h00060);
    check("ior_io", 32'(r_io), 32'd1);
    check("ior_nrd_low", 32'(r_nrd), 32'd8);
    check("ior_enout_cycles", 32'(r_en), 32'd0);
    check("ior_rdata", r_data, 32'h5A5A_5A5A);
    check("ior_rresp", 32'(r_resp), 32'd0);

    // Three wait states: READY low at samples in cycles 12,16,20, high at 24.
    issue_rd(32'h0000_4321, "ws");
    run_to_resp(1'b1, 1'b1, 24, 8'h11, 8'hC3);
    check("ws_latency", 32'(r_lat), 32'd29);
    check("ws_nrd_low", 32'(r_nrd), 32'd20);
    check("ws_rdata", r_data, 32'hC3C3_C3C3);
    check("ws_rresp", 32'(r_resp), 32'd0);

    // Timeout: READY never rises -> 64 TW, SLVERR, all-ones data.
    issue_rd(32'h0020_0001, "to");
    run_to_resp(1'b1, 1'b1, 1_000_000, 8'h00, 8'h00);
    check("to_latency", 32'(r_lat), 32'd273);
    check("to_nrd_low", 32'(r_nrd), 32'd264);
    check("to_rdata", r_data, 32'hFFFF_FFFF);
    check("to_rresp", 32'(r_resp), 32'd2);

    // Normal IO write right after the timeout, lane 2.
    issue_wr(32'h0020_0002, 32'h00CD_0000, 4'b0100, "iow");
    run_to_resp(1'b1, 1'b1, 0, 8'h00, 8'h00);
    check("iow_latency", 32'(r_lat), 32'd17);
    check("iow_io", 32'(r_io), 32'd1);
    check("iow_ad8", 32'(r_ad), 32'hCD);
    check("iow_bresp", 32'(r_resp), 32'd0);

    // Write whose addressed lane (1) is not strobed: no bus cycle, SLVERR.
    issue_wr(32'h0000_0001, 32'h0000_EE00, 4'b1101, "bs");
    run_to_resp(1'b1, 1'b1, 0, 8'h00, 8'h00);
    check("bs_latency", 32'(r_lat), 32'd1);
    check("bs_bus_activity", 32'(r_ale + r_nwr + r_en), 32'd0);
    check("bs_bresp", 32'(r_resp), 32'd2);

    // Arbitration: write wins, read waits until the held B response completes.
    @(posedge AXI_CLK); #1;
    AXI_bready = 1'b0;
    AXI_awaddr = 32'h0000_0010; AXI_wdata = 32'h0000_0042; AXI_wstrb = 4'b0001;
    AXI_awvalid = 1'b1; AXI_wvalid = 1'b1;
    AXI_araddr = 32'h0000_0020; AXI_arvalid = 1'b1;
    @(negedge AXI_CLK);
    check("arb_awready", 32'(AXI_awready), 32'd1);
    check("arb_arready_lost", 32'(AXI_arready), 32'd0);
    run_to_resp(1'b1, 1'b0, 0, 8'h9E, 8'h9E);
    check("arb_w_latency", 32'(r_lat), 32'd17);
    check("arb_ar_during_w", 32'(r_ar_seen), 32'd0);
    check("arb_ad8", 32'(r_ad), 32'h42);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge AXI_CLK); #1;
      @(negedge AXI_CLK);
      if (!AXI_bvalid || AXI_bresp !== 2'b00 || AXI_arready) bad++;
    end
    check("arb_b_hold", 32'(bad), 32'd0);
    @(posedge AXI_CLK); #1;
    AXI_bready = 1'b1;
    @(negedge AXI_CLK);
    check("arb_ar_before_hs", 32'(AXI_arready), 32'd0);
    @(posedge AXI_CLK); #1;
    @(negedge AXI_CLK);
    check("arb_ar_after_hs", 32'(AXI_arready), 32'd1);
    run_to_resp(1'b1, 1'b1, 0, 8'h9E, 8'h9E);
    check("arb_r_latency", 32'(r_lat), 32'd17);
    check("arb_rdata", r_data, 32'h9E9E_9E9E);

    // Reset during T2 of a write.
    issue_wr(32'h0004_5670, 32'h0000_0077, 4'b0001, "rw");
    for (int k = 1; k <= 6; k++) begin
      @(posedge AXI_CLK); #1;
      if (k == 1) begin AXI_awvalid = 1'b0; AXI_wvalid = 1'b0; end
    end
    @(negedge AXI_CLK);
    check("rw_t2_strobes", {30'd0, nWR_bus, AD8_enout_bus}, 32'h1);
    #2;
    RESET = 1'b1;
    #1;
    check("rw_async_strobes", {28'd0, nWR_bus, AD8_enout_bus, ALE_bus, nRD_bus}, 32'h9);
    check("rw_async_A_bus", 32'(A_bus), 32'd0);
    bad = 0;
    repeat (2) begin
      @(negedge AXI_CLK);
      if (AXI_bvalid) bad++;
    end
    @(posedge AXI_CLK); #1;
    RESET = 1'b0;
    repeat (25) begin
      @(negedge AXI_CLK);
      if (AXI_bvalid || AXI_rvalid || !nWR_bus || ALE_bus) bad++;
    end
    check("rw_no_resp", 32'(bad), 32'd0);
    issue_rd(32'h0000_0AAA, "rr");
    run_to_resp(1'b1, 1'b1, 0, 8'h3C, 8'h3C);
    check("rr_latency", 32'(r_lat), 32'd17);
    check("rr_rdata", r_data, 32'h3C3C_3C3C);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
